// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART blocks: FSM state encoding,
// parity-mode codes and the 3-sample majority helper.
package uart_pkg;

    localparam int UART_STATE_W = 3;

    typedef enum logic [UART_STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_DATA    = 3'd2,
        ST_PARITY  = 3'd3,
        ST_STOP    = 3'd4,
        ST_RECOVER = 3'd5
    } uart_state_t;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous level input, with a
// configurable reset value so idle-high lines come out of reset idle.
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_d,
    output logic o_q
);

    logic meta;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            meta <= RESET_VAL;
            o_q  <= RESET_VAL;
        end else begin
            meta <= i_d;
            o_q  <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_cfg.sv
// Parametrised oversampling UART receiver with runtime parity, majority-vote
// bit sampling, false-start rejection and framing/parity/break reporting.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int DBIT    = 8,
    parameter int OVS     = 16,
    parameter int SB_TICK = 16
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_rx,
    input  logic            i_s_tick,
    input  logic [1:0]      i_par_mode,
    output logic            o_rx_done,
    output logic [DBIT-1:0] o_rx,
    output logic            o_parity_err,
    output logic            o_frame_err,
    output logic            o_break
);

    localparam int S_MAX = (OVS > SB_TICK) ? OVS : SB_TICK;
    localparam int SW    = $clog2(S_MAX);
    localparam int NW    = $clog2(DBIT);

    localparam logic [SW-1:0] S_HALF = SW'(OVS / 2 - 1);
    localparam logic [SW-1:0] S_SMP0 = SW'(OVS - 3);
    localparam logic [SW-1:0] S_SMP1 = SW'(OVS - 2);
    localparam logic [SW-1:0] S_LAST = SW'(OVS - 1);
    localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

    uart_state_t     state;
    logic            rx_s;
    logic [SW-1:0]   s;
    logic [NW-1:0]   n;
    logic [DBIT-1:0] shreg;
    logic [1:0]      par_q;
    logic            par_acc;
    logic            par_bit;
    logic            perr_q;
    logic            ferr_q;
    logic            smp0;
    logic            smp1;
    logic            vote;
    logic            par_en;
    logic            ferr_now;

    uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_d     (i_rx),
        .o_q     (rx_s)
    );

    // The third sample is the live synchronised line on the deciding tick.
    assign vote     = maj3(smp0, smp1, rx_s);
    assign par_en   = (par_q == PAR_EVEN) || (par_q == PAR_ODD);
    assign ferr_now = ferr_q | ((s == S_LAST) & ~vote);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state        <= ST_IDLE;
            s            <= '0;
            n            <= '0;
            shreg        <= '0;
            par_q        <= PAR_NONE;
            par_acc      <= 1'b0;
            par_bit      <= 1'b0;
            perr_q       <= 1'b0;
            ferr_q       <= 1'b0;
            smp0         <= 1'b0;
            smp1         <= 1'b0;
            o_rx_done    <= 1'b0;
            o_rx         <= '0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
            o_break      <= 1'b0;
        end else begin
            o_rx_done <= 1'b0;
            if (i_s_tick) begin
                if (s == S_SMP0) smp0 <= rx_s;
                if (s == S_SMP1) smp1 <= rx_s;
            end
            case (state)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state   <= ST_START;
                        s       <= '0;
                        par_q   <= i_par_mode;
                        par_acc <= 1'b0;
                        par_bit <= 1'b0;
                        perr_q  <= 1'b0;
                        ferr_q  <= 1'b0;
                    end
                end
                ST_START: begin
                    if (i_s_tick) begin
                        if (s == S_HALF) begin
                            if (rx_s) begin
                                state <= ST_IDLE;
                            end else begin
                                state <= ST_DATA;
                                s     <= '0;
                                n     <= '0;
                            end
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    if (i_s_tick) begin
                        if (s == S_LAST) begin
                            shreg   <= {vote, shreg[DBIT-1:1]};
                            par_acc <= par_acc ^ vote;
                            s       <= '0;
                            if (n == N_LAST) state <= par_en ? ST_PARITY : ST_STOP;
                            else             n     <= n + 1'b1;
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (i_s_tick) begin
                        if (s == S_LAST) begin
                            par_bit <= vote;
                            perr_q  <= (vote ^ par_acc) != (par_q == PAR_ODD);
                            s       <= '0;
                            state   <= ST_STOP;
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                // The stop counter runs past OVS so 1.5 and 2 stop bits work.
                ST_STOP: begin
                    if (i_s_tick) begin
                        if (s == S_STOP) begin
                            o_rx_done    <= 1'b1;
                            o_rx         <= shreg;
                            o_parity_err <= perr_q;
                            o_frame_err  <= ferr_now;
                            o_break      <= ferr_now && (shreg == '0) && !(par_en && par_bit);
                            s            <= '0;
                            state        <= ferr_now ? ST_RECOVER : ST_IDLE;
                        end else begin
                            ferr_q <= ferr_now;
                            s      <= s + 1'b1;
                        end
                    end
                end
                ST_RECOVER: begin
                    if (rx_s) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
